// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: default widths,
// FSM state encoding and the issue-admission rule.
package inst_fetch_ctrl_pkg;

    localparam int unsigned FETCH_ADDR_W   = 6;
    localparam int unsigned FETCH_DATA_W   = 32;
    localparam int unsigned FETCH_RESET_PC = 0;
    localparam int unsigned FETCH_BUF_DEPTH = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // A new ROM read may start only if every word already owed to the buffer
    // (stored + landing this edge - leaving this edge) leaves a free slot.
    function automatic logic issue_allowed(input logic [1:0] count,
                                           input logic       inflight,
                                           input logic       pop);
        return ({1'b0, count} + {2'b00, inflight}) <
               (3'(FETCH_BUF_DEPTH) + {2'b00, pop});
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_skid_buf.sv
// Two-entry {pc, inst} FIFO: an output register feeding decode plus one skid
// slot that absorbs the word still in flight when decode stalls.
module inst_fetch_ctrl_skid_buf
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic              head_valid_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_data_o
);

    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [1:0]        count_q, count_d;
    logic              do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    always_comb begin
        head_pc_d   = head_pc_q;
        head_data_d = head_data_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        count_d     = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_d   = push_pc_i;
                        head_data_d = push_data_i;
                        count_d     = 2'd1;
                    end else if (count_q == 2'd1) begin
                        skid_pc_d   = push_pc_i;
                        skid_data_d = push_data_i;
                        count_d     = 2'd2;
                    end
                end
                2'b01: begin
                    head_pc_d   = skid_pc_q;
                    head_data_d = skid_data_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word goes behind whatever remains.
                    if (count_q == 2'd1) begin
                        head_pc_d   = push_pc_i;
                        head_data_d = push_data_i;
                    end else begin
                        head_pc_d   = skid_pc_q;
                        head_data_d = skid_data_q;
                        skid_pc_d   = push_pc_i;
                        skid_data_d = push_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_pc_q   <= '0;
            head_data_q <= '0;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            count_q     <= 2'd0;
        end else begin
            head_pc_q   <= head_pc_d;
            head_data_q <= head_data_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            count_q     <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_pc_o    = head_pc_q;
    assign head_data_o  = head_data_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the block-ROM address,
// and delivers PC-tagged instructions to decode with back-pressure and redirect.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned DATA_W   = FETCH_DATA_W,
    parameter int unsigned RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              id_ready,
    output fetch_state_e      dbg_state_o
);

    // Handshake: a word moves to decode on any rising edge where inst_valid
    // and id_ready are both 1; inst/inst_pc never change while inst_valid=1
    // and id_ready=0. A redirect in the same cycle still consumes the word.

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        buf_count;
    logic              pop;
    logic              issue_ok;
    logic              buf_push;
    logic              buf_pop;

    assign pop      = inst_valid & id_ready;
    assign issue_ok = (state_q == ST_RUN) && fetch_en && !redirect &&
                      issue_allowed(buf_count, inflight_q, pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fetch_en)  state_d = ST_RUN;
            ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue_ok) begin
            pc_d       = pc_q + ADDR_W'(1);
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_ADDR;
            req_pc_q   <= RESET_ADDR;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // The word landing from the ROM is dropped on redirect; it belongs to the old path.
    assign buf_push = inflight_q & ~redirect;
    assign buf_pop  = pop & ~redirect;

    inst_fetch_ctrl_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk_i        (clk),
        .rst_ni       (rst),
        .flush_i      (redirect),
        .push_i       (buf_push),
        .push_pc_i    (req_pc_q),
        .push_data_i  (rom_data),
        .pop_i        (buf_pop),
        .count_o      (buf_count),
        .head_valid_o (inst_valid),
        .head_pc_o    (inst_pc),
        .head_data_o  (inst)
    );

    assign rom_addr    = pc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: cycle table, directed corner sequences and a
// randomized run checked against a PC-stream scoreboard.
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          id_ready;
    fetch_state_e  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .id_ready    (id_ready),
        .dbg_state_o (dbg_state)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    // Synchronous-read ROM: address registered, data valid the following cycle.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic d,
                         input logic [AW-1:0] dpc, input logic y);
        rst         = r;
        fetch_en    = f;
        redirect    = d;
        redirect_pc = dpc;
        id_ready    = y;
    endtask

    task automatic do_reset(input logic f);
        @(negedge clk);
        drive(1'b0, f, 1'b0, '0, 1'b1);
    endtask

    typedef struct {
        logic          r, f, d;
        logic [AW-1:0] dpc;
        logic          y;
        logic          ev;
        logic [AW-1:0] epc;
        logic [AW-1:0] eaddr;
        logic          zero;
    } vec_t;

    function automatic vec_t v(input logic r, input logic f, input logic d, input int dpc,
                               input logic y, input logic ev, input int epc, input int ea,
                               input logic z);
        vec_t t;
        t.r = r; t.f = f; t.d = d; t.dpc = AW'(dpc); t.y = y;
        t.ev = ev; t.epc = AW'(epc); t.eaddr = AW'(ea); t.zero = z;
        return t;
    endfunction

    vec_t tbl[32];

    logic [AW-1:0] exp_q[$];

    initial begin
        int n;
        logic first;
        logic found;
        logic hold;
        logic flushed;
        logic [AW-1:0] flush_addr;
        logic [AW-1:0] held_pc;
        logic [DW-1:0] held_inst;
        logic [AW-1:0] nxt;
        logic r, f, d, y;
        logic [AW-1:0] dpc;
        int transfers;

        // reset, start-up latency, streaming, back-pressure, redirect, stop/start, reset
        tbl[0]  = v(0,1,0,0,1, 0,0,0,1);
        tbl[1]  = v(0,1,0,0,1, 0,0,0,1);
        tbl[2]  = v(1,1,0,0,1, 0,0,0,1);
        tbl[3]  = v(1,1,0,0,1, 0,0,0,0);
        tbl[4]  = v(1,1,0,0,1, 0,0,1,0);
        tbl[5]  = v(1,1,0,0,1, 1,0,2,0);
        tbl[6]  = v(1,1,0,0,1, 1,1,3,0);
        tbl[7]  = v(1,1,0,0,1, 1,2,4,0);
        tbl[8]  = v(1,1,0,0,1, 1,3,5,0);
        tbl[9]  = v(1,1,0,0,0, 1,4,6,0);
        tbl[10] = v(1,1,0,0,0, 1,4,6,0);
        tbl[11] = v(1,1,0,0,0, 1,4,6,0);
        tbl[12] = v(1,1,0,0,0, 1,4,6,0);
        tbl[13] = v(1,1,0,0,0, 1,4,6,0);
        tbl[14] = v(1,1,0,0,1, 1,4,6,0);
        tbl[15] = v(1,1,0,0,1, 1,5,7,0);
        tbl[16] = v(1,1,0,0,1, 1,6,8,0);
        tbl[17] = v(1,1,1,40,1, 1,7,9,0);
        tbl[18] = v(1,1,0,0,1, 0,0,40,0);
        tbl[19] = v(1,1,0,0,1, 0,0,41,0);
        tbl[20] = v(1,0,0,0,1, 1,40,42,0);
        tbl[21] = v(1,0,0,0,1, 1,41,42,0);
        tbl[22] = v(1,0,0,0,1, 0,0,42,0);
        tbl[23] = v(1,1,0,0,1, 0,0,42,0);
        tbl[24] = v(1,1,0,0,1, 0,0,42,0);
        tbl[25] = v(1,1,0,0,1, 0,0,43,0);
        tbl[26] = v(1,1,0,0,1, 1,42,44,0);
        tbl[27] = v(0,1,0,0,1, 1,43,45,0);
        tbl[28] = v(1,1,0,0,1, 0,0,0,1);
        tbl[29] = v(1,1,0,0,1, 0,0,0,0);
        tbl[30] = v(1,1,0,0,1, 0,0,1,0);
        tbl[31] = v(1,1,0,0,1, 1,0,2,0);

        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(tbl[i].r, tbl[i].f, tbl[i].d, tbl[i].dpc, tbl[i].y);
            check($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_rom_addr", i), 32'(rom_addr), 32'(tbl[i].eaddr));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_inst_pc", i), 32'(inst_pc), 32'(tbl[i].epc));
                check($sformatf("tbl%0d_inst", i), inst, rom_word(tbl[i].epc));
            end
            if (tbl[i].zero) begin
                check($sformatf("tbl%0d_inst_rst", i), inst, 32'h0);
                check($sformatf("tbl%0d_inst_pc_rst", i), 32'(inst_pc), 32'h0);
            end
        end

        // Long stream with decode always ready: contiguous PCs, wrap at 64, no bubbles.
        do_reset(1'b1);
        n = 0;
        first = 1'b0;
        for (int c = 0; c < 80 && n < 70; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            if (first) check("stream_gap", 32'(inst_valid), 32'h1);
            if (inst_valid) begin
                check("stream_pc", 32'(inst_pc), 32'(n % 64));
                check("stream_inst", inst, rom_word(AW'(n)));
                n++;
                first = 1'b1;
            end
        end
        check("stream_count", 32'(n), 32'd70);

        // Reset in the middle of a stream, with a word in flight.
        do_reset(1'b1);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            if (inst_valid && inst_pc == AW'(20)) found = 1'b1;
        end
        check("midrst_reach_pc20", 32'(found), 32'h1);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        check("midrst_valid", 32'(inst_valid), 32'h0);
        check("midrst_inst", inst, 32'h0);
        check("midrst_inst_pc", 32'(inst_pc), 32'h0);
        check("midrst_rom_addr", 32'(rom_addr), 32'h0);
        first = 1'b0;
        for (int c = 0; c < 6 && !first; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            if (inst_valid) begin
                first = 1'b1;
                check("midrst_restart_pc", 32'(inst_pc), 32'h0);
                check("midrst_restart_lat", 32'(c), 32'd2);
            end
        end
        check("midrst_restart_seen", 32'(first), 32'h1);

        // Redirect while idle only moves the PC; then fetch_en fall together with redirect.
        do_reset(1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, AW'(10), 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("idle_redir_addr", 32'(rom_addr), 32'd10);
        check("idle_redir_valid", 32'(inst_valid), 32'h0);
        check("idle_redir_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        check("idle_no_issue_addr", 32'(rom_addr), 32'd10);
        first = 1'b0;
        for (int c = 0; c < 8 && !first; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            if (inst_valid) begin
                first = 1'b1;
                check("idle_redir_first_pc", 32'(inst_pc), 32'd10);
            end
        end
        check("idle_redir_first_seen", 32'(first), 32'h1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, AW'(50), 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            check("stop_redir_valid", 32'(inst_valid), 32'h0);
            check("stop_redir_addr", 32'(rom_addr), 32'd50);
        end
        check("stop_redir_state", 32'(dbg_state), 32'(ST_IDLE));

        // Random run: every accepted word must continue the expected PC stream.
        do_reset(1'b1);
        exp_q.delete();
        exp_q.push_back(AW'(0));
        flushed = 1'b1;
        flush_addr = '0;
        hold = 1'b0;
        held_pc = '0;
        held_inst = '0;
        transfers = 0;
        f = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (flushed) begin
                check("rand_flush_valid", 32'(inst_valid), 32'h0);
                check("rand_flush_addr", 32'(rom_addr), 32'(flush_addr));
            end
            if (hold) begin
                check("rand_hold_valid", 32'(inst_valid), 32'h1);
                check("rand_hold_pc", 32'(inst_pc), 32'(held_pc));
                check("rand_hold_inst", inst, held_inst);
            end
            r   = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) f = ~f;
            d   = ($urandom_range(0, 39) == 0);
            dpc = AW'($urandom_range(0, 63));
            y   = ($urandom_range(0, 3) != 0);
            drive(r, f, d, dpc, y);
            flushed = 1'b0;
            hold = 1'b0;
            if (!r) begin
                exp_q.delete();
                exp_q.push_back(AW'(0));
                flushed = 1'b1;
                flush_addr = '0;
            end else if (d) begin
                exp_q.delete();
                exp_q.push_back(dpc);
                flushed = 1'b1;
                flush_addr = dpc;
            end else if (inst_valid && y) begin
                check("rand_pc", 32'(inst_pc), 32'(exp_q[0]));
                check("rand_inst", inst, rom_word(exp_q[0]));
                nxt = exp_q.pop_front() + AW'(1);
                exp_q.push_back(nxt);
                transfers++;
            end else if (inst_valid) begin
                hold = 1'b1;
                held_pc = inst_pc;
                held_inst = inst;
            end
        end
        check("rand_progress", 32'(transfers > 500), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
